l2_arbiter: RTL and testbench

Two-port arbiter that shares the single L2 cache between the L1 instruction cache and the L1 data cache. It sits between both L1 cache controllers' physical-memory ports and the L2 cache's CPU-side port. It latches one request at a time and forwards it to L2. It returns the L2 response only to the granted requester. Ties are broken round-robin.

---
 rtl/l2_arbiter.sv | 97 +++++++++
 tb/tb_l2_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_arbiter.sv
// Round-robin arbiter sharing one L2 port between the L1 I-cache and D-cache.
// One request is latched per transfer; the L2 response is routed only to its owner.
module l2_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_address,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_e;

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;  // 0 = I, 1 = D
  logic              op_write_q, op_write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;

  logic i_valid, d_valid, pick_d;

  // Both d_read and d_write high is malformed and treated as no request.
  assign i_valid = i_read;
  assign d_valid = d_read ^ d_write;
  assign pick_d  = d_valid && (!i_valid || !last_grant_q);

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_write_d   = op_write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (i_valid || d_valid) begin
          last_grant_d = pick_d;
          state_d      = pick_d ? SERVE_D : SERVE_I;
          op_write_d   = pick_d && d_write;
          addr_d       = pick_d ? d_address : i_address;
          wdata_d      = (pick_d && d_write) ? d_wdata : '0;
        end
      end
      SERVE_I, SERVE_D: begin
        if (l2_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      op_write_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_write_q   <= op_write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  logic serving;
  assign serving = (state_q != IDLE);

  // L2 side is driven purely from latched state, never from requester inputs.
  assign l2_read    = serving && !op_write_q;
  assign l2_write   = serving && op_write_q;
  assign l2_address = serving ? addr_q : '0;
  assign l2_wdata   = (serving && op_write_q) ? wdata_q : '0;

  assign i_resp  = (state_q == SERVE_I) && l2_resp;
  assign d_resp  = (state_q == SERVE_D) && l2_resp;
  assign i_rdata = l2_rdata;
  assign d_rdata = l2_rdata;

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed testbench for l2_arbiter: inputs change 1ns after posedge, outputs checked at negedge.
module tb_l2_arbiter;

  localparam int ADDR_W = 16;
  localparam int LINE_W = 128;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_read, d_read, d_write, l2_resp;
  logic [ADDR_W-1:0] i_address, d_address;
  logic [LINE_W-1:0] d_wdata, l2_rdata;
  logic [LINE_W-1:0] i_rdata, d_rdata, l2_wdata;
  logic              i_resp, d_resp, l2_read, l2_write;
  logic [ADDR_W-1:0] l2_address;

  int errors = 0;
  int checks = 0;

  localparam logic [LINE_W-1:0] LINE_A5   = {16{8'hA5}};
  localparam logic [LINE_W-1:0] LINE_1234 = {8{16'h1234}};

  l2_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address),
    .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_read = 0; d_read = 0; d_write = 0; l2_resp = 0;
    i_address = '0; d_address = '0; d_wdata = '0; l2_rdata = '0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_reset();
    idle_inputs();
    l2_rdata = LINE_A5;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({l2_read, l2_write, i_resp, d_resp} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: got %b exp 0000", {l2_read, l2_write, i_resp, d_resp});
    end
    checks++;
    if (l2_address !== '0 || l2_wdata !== '0) begin
      errors++; $display("FAIL reset_addr_wdata: got %h/%h exp 0/0", l2_address, l2_wdata);
    end
    checks++;
    if (i_rdata !== LINE_A5 || d_rdata !== LINE_A5) begin
      errors++; $display("FAIL reset_rdata_passthru: got %h/%h exp %h", i_rdata, d_rdata, LINE_A5);
    end
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_single_i_read();
    i_read = 1; i_address = 16'h0040;
    @(negedge clk);
    checks++;
    if (l2_read !== 1'b0) begin
      errors++; $display("FAIL i_read_arb_cycle: l2_read got %b exp 0", l2_read);
    end
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      if (c == 3) begin l2_resp = 1; l2_rdata = LINE_A5; end
      @(negedge clk);
      checks++;
      if (l2_read !== 1'b1 || l2_write !== 1'b0 || l2_address !== 16'h0040) begin
        errors++; $display("FAIL i_read_l2 c%0d: got rd=%b wr=%b addr=%h exp 1/0/0040", c, l2_read, l2_write, l2_address);
      end
      checks++;
      if (i_resp !== (c == 3) || d_resp !== 1'b0) begin
        errors++; $display("FAIL i_read_resp c%0d: got i=%b d=%b exp %b/0", c, i_resp, d_resp, c == 3);
      end
    end
    checks++;
    if (i_rdata !== LINE_A5) begin
      errors++; $display("FAIL i_read_rdata: got %h exp %h", i_rdata, LINE_A5);
    end
    next_cycle();
    i_read = 0; l2_resp = 0;
    @(negedge clk);
    checks++;
    if (l2_read !== 1'b0 || i_resp !== 1'b0) begin
      errors++; $display("FAIL i_read_back_idle: got rd=%b resp=%b exp 0/0", l2_read, i_resp);
    end
    next_cycle();
  endtask

  task automatic test_d_write();
    d_write = 1; d_address = 16'h1230; d_wdata = LINE_1234;
    next_cycle();
    l2_resp = 1;
    @(negedge clk);
    checks++;
    if (l2_write !== 1'b1 || l2_read !== 1'b0 || l2_address !== 16'h1230) begin
      errors++; $display("FAIL d_write_l2: got wr=%b rd=%b addr=%h exp 1/0/1230", l2_write, l2_read, l2_address);
    end
    checks++;
    if (l2_wdata !== LINE_1234) begin
      errors++; $display("FAIL d_write_wdata: got %h exp %h", l2_wdata, LINE_1234);
    end
    checks++;
    if (d_resp !== 1'b1 || i_resp !== 1'b0) begin
      errors++; $display("FAIL d_write_resp: got d=%b i=%b exp 1/0", d_resp, i_resp);
    end
    next_cycle();
    d_write = 0; l2_resp = 0;
    @(negedge clk);
    checks++;
    if (l2_write !== 1'b0 || l2_read !== 1'b0 || l2_wdata !== '0) begin
      errors++; $display("FAIL d_write_idle: got wr=%b rd=%b wdata=%h exp idle", l2_write, l2_read, l2_wdata);
    end
    next_cycle();
  endtask

  task automatic test_round_robin();
    logic exp_d;
    apply_reset();
    i_read = 1; i_address = 16'h0300;
    d_read = 1; d_address = 16'h0400;
    for (int t = 0; t < 4; t++) begin
      exp_d = (t % 2) == 1;
      @(negedge clk);
      checks++;
      if (l2_read !== 1'b0) begin
        errors++; $display("FAIL rr_arb_idle t%0d: l2_read got %b exp 0", t, l2_read);
      end
      next_cycle();
      l2_resp = 1;
      @(negedge clk);
      checks++;
      if (l2_read !== 1'b1 || l2_address !== (exp_d ? 16'h0400 : 16'h0300)) begin
        errors++; $display("FAIL rr_grant t%0d: got rd=%b addr=%h exp 1/%h", t, l2_read, l2_address, exp_d ? 16'h0400 : 16'h0300);
      end
      checks++;
      if (i_resp !== !exp_d || d_resp !== exp_d) begin
        errors++; $display("FAIL rr_resp t%0d: got i=%b d=%b exp %b/%b", t, i_resp, d_resp, !exp_d, exp_d);
      end
      next_cycle();
      l2_resp = 0;
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_addr_hold();
    d_read = 1; d_address = 16'h0100;
    next_cycle();
    d_address = 16'h0200;
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) l2_resp = 1;
      @(negedge clk);
      checks++;
      if (l2_address !== 16'h0100 || l2_read !== 1'b1) begin
        errors++; $display("FAIL addr_hold c%0d: got addr=%h rd=%b exp 0100/1", c, l2_address, l2_read);
      end
      checks++;
      if (d_resp !== (c == 3)) begin
        errors++; $display("FAIL addr_hold_resp c%0d: got %b exp %b", c, d_resp, c == 3);
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_illegal_request();
    d_read = 1; d_write = 1; d_address = 16'h0777;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) l2_resp = 1;
      @(negedge clk);
      checks++;
      if ({l2_read, l2_write, i_resp, d_resp} !== 4'b0000) begin
        errors++; $display("FAIL illegal_req c%0d: got %b exp 0000", c, {l2_read, l2_write, i_resp, d_resp});
      end
      next_cycle();
      l2_resp = 0;
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_reset_mid_serve();
    d_read = 1; d_address = 16'h0500;
    next_cycle();
    @(negedge clk);
    checks++;
    if (l2_read !== 1'b1 || l2_address !== 16'h0500) begin
      errors++; $display("FAIL rst_mid_pre: got rd=%b addr=%h exp 1/0500", l2_read, l2_address);
    end
    #2;
    rst = 1'b1;
    l2_resp = 1;
    i_read = 1; i_address = 16'h0600;
    #1;
    checks++;
    if ({l2_read, l2_write, d_resp, i_resp} !== 4'b0000 || l2_address !== '0) begin
      errors++; $display("FAIL rst_mid_abort: got ctrl=%b addr=%h exp 0000/0", {l2_read, l2_write, d_resp, i_resp}, l2_address);
    end
    @(negedge clk);
    rst = 1'b0;
    l2_resp = 0;
    @(negedge clk);
    checks++;
    if (l2_read !== 1'b1 || l2_address !== 16'h0600) begin
      errors++; $display("FAIL rst_then_i_priority: got rd=%b addr=%h exp 1/0600", l2_read, l2_address);
    end
    #6;
    l2_resp = 1;
    @(negedge clk);
    checks++;
    if (i_resp !== 1'b1 || d_resp !== 1'b0) begin
      errors++; $display("FAIL rst_then_i_resp: got i=%b d=%b exp 1/0", i_resp, d_resp);
    end
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_single_i_read();
    test_d_write();
    test_round_robin();
    test_addr_hold();
    test_illegal_request();
    test_reset_mid_serve();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
